// File: rtl/imem_pkg.sv
// ============================================================================
// Module : imem_pkg
// Brief  : Shared constants and state encoding for the instruction-memory
//          fetch controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_pkg;

  localparam int          ADDR_W_DEF  = 16;
  localparam logic [5:0]  HALT_OP_DEF = 6'h3F;
  localparam logic [31:0] NOOP        = 32'h0000_0000;

  localparam logic [1:0]  ST_BOOT = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_HALT = 2'd2;

  typedef enum logic [1:0] {
    S_BOOT = ST_BOOT,
    S_RUN  = ST_RUN,
    S_HALT = ST_HALT
  } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module : imem_fetch_ctrl
// Brief  : Boot-loads an external instruction memory, then serves single-
//          outstanding fetches with 1-cycle latency. Optional halt-opcode
//          detection is enabled by defining IMEM_HALT_DETECT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter logic [5:0] HALT_OP = HALT_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // boot loader
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  // fetch
  input  logic              fe_req,
  input  logic [31:0]       fe_addr,
  output logic              fe_gnt,
  output logic [31:0]       instr,
  output logic              instr_valid,
  // memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // control / status
  input  logic              reload,
  output logic [1:0]        state,
  output logic              halted,
  output logic              addr_err
);

  state_e      r_state;
  logic        r_pending;
  logic        r_err;
  logic [31:0] r_instr;

  logic        w_boot;
  logic        w_run;
  logic        w_ld_fire;
  logic        w_in_range;
  logic        w_gnt;
  logic        w_halt_ret;
  logic [31:0] w_instr;

  assign w_boot     = (r_state == S_BOOT);
  assign w_run      = (r_state == S_RUN);
  // rst gates every strobe so an asserted reset never issues a write or read
  assign w_ld_fire  = rst && w_boot && ld_valid;
  assign w_in_range = ((fe_addr >> ADDR_W) == 32'd0);
  assign w_instr    = r_pending ? (r_err ? NOOP : mem_rdata) : r_instr;

`ifdef IMEM_HALT_DETECT_EN
  assign w_halt_ret = w_run && r_pending && (w_instr[31:26] == HALT_OP);
  assign halted     = (r_state == S_HALT);
`else
  logic w_unused_halt_op;
  assign w_unused_halt_op = ^HALT_OP;
  assign w_halt_ret       = 1'b0;
  assign halted           = 1'b0;
`endif

  assign w_gnt = rst && w_run && fe_req && !w_halt_ret;

  assign ld_ready    = rst && w_boot;
  assign fe_gnt      = w_gnt;
  assign mem_en      = w_ld_fire || (w_gnt && w_in_range);
  assign mem_we      = w_ld_fire;
  assign mem_addr    = w_boot ? ld_addr : fe_addr[ADDR_W-1:0];
  assign mem_wdata   = ld_data;
  assign instr       = w_instr;
  assign instr_valid = r_pending;
  assign addr_err    = r_pending && r_err;
  assign state       = r_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_BOOT;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_instr   <= NOOP;
    end else begin
      if (r_pending)
        r_instr <= w_instr;
      r_pending <= w_gnt;
      r_err     <= w_gnt && !w_in_range;
      case (r_state)
        S_BOOT: begin
          if (w_ld_fire && ld_last)
            r_state <= S_RUN;
        end
        S_RUN: begin
          // reload outranks a halt word returning in the same cycle
          if (reload) begin
            r_state   <= S_BOOT;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
          end else if (w_halt_ret) begin
            r_state <= S_HALT;
          end
        end
        S_HALT: begin
          if (reload)
            r_state <= S_BOOT;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width of instruction memory (65536 words).
REQ-002 SHALL have parameter HALT_OP, default 6'h3F, opcode field instr[31:26] meaning halt.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have loader ports: ld_valid in 1; ld_ready out 1; ld_addr in ADDR_W; ld_data in 32; ld_last in 1 (final boot word).
REQ-006 SHALL have fetch ports: fe_req in 1; fe_addr in 32 (word index from PC); fe_gnt out 1; instr out 32; instr_valid out 1.
REQ-007 SHALL have memory ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out 32; mem_rdata in 32 (registered read, 1-cycle latency).
REQ-008 SHALL have control/status ports: reload in 1; state out 2; halted out 1; addr_err out 1.

Function
REQ-009 SHALL implement FSM BOOT=2'd0, RUN=2'd1, HALT=2'd2; state output equals the current state; 2'd3 is unreachable and SHALL recover to BOOT.
REQ-010 In BOOT: ld_ready=1, fe_gnt=0; each ld_valid&ld_ready cycle drives mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data.
REQ-011 BOOT->RUN on the cycle after a write with ld_last=1.
REQ-012 In RUN: ld_ready=0; fe_gnt=fe_req; a granted cycle drives mem_en=1, mem_we=0, mem_addr=fe_addr[ADDR_W-1:0].
REQ-013 Fetch latency exactly 1 cycle: grant in cycle N -> instr=mem_rdata and instr_valid=1 in cycle N+1; back-to-back grants each cycle SHALL yield back-to-back valid instructions.
REQ-014 instr_valid SHALL be 0 in any cycle not preceded by a grant; instr holds its last value when not valid.
REQ-015 fe_addr with any nonzero bit above ADDR_W-1: granted but no memory access (mem_en=0); next cycle instr=32'h0 (noop), instr_valid=1, addr_err=1 for that one cycle.
REQ-016 At most one fetch outstanding; no internal queue beyond the instr register.
REQ-017 halted=1 exactly while state==HALT; in HALT fe_gnt=0, ld_ready=0, mem_en=0.
REQ-018 reload=1 in RUN or HALT SHALL move to BOOT next cycle and discard any in-flight fetch (instr_valid=0 next cycle); reload in BOOT is ignored.
REQ-019 reload and a halt-instruction return in the same cycle: reload wins (next state BOOT).

Reset
REQ-020 While rst=0 at posedge: state=BOOT, instr=32'h0, instr_valid=0, addr_err=0, in-flight fetch discarded; memory contents untouched.
REQ-021 Outputs derived from state (ld_ready, fe_gnt, halted, mem_*) SHALL reflect BOOT in the first cycle after reset release; reset asserted mid-boot or mid-fetch aborts the operation with no write issued that cycle.

Configuration
REQ-022 Macro IMEM_HALT_DETECT_EN: when defined, a returned valid instr with instr[31:26]==HALT_OP moves RUN->HALT next cycle and suppresses fe_gnt combinationally in that return cycle; the halt word itself is still delivered with instr_valid=1.
REQ-023 Without IMEM_HALT_DETECT_EN: HALT is never entered, halted is tied 0, HALT_OP is unused.

Structure
REQ-024 Shared package imem_pkg SHALL hold the state encoding constants, NOOP=32'h0, the HALT_OP default, and the ADDR_W default.
REQ-025 The FSM and handshake logic SHALL be in one module with no sub-module; the memory array stays external.

Verification
REQ-026 Boot: 3 writes to addr 0,1,2 (last on addr 2) -> mem_we pulses 3 cycles, state=RUN one cycle after the third write.
REQ-027 Fetch: fe_req with fe_addr=0,1,2 on consecutive cycles -> instr_valid 3 consecutive cycles, instr matching the loaded words, 1-cycle latency.
REQ-028 Range: fe_addr=32'h0001_0000 -> next cycle instr=0, instr_valid=1, addr_err=1, mem_en=0 in the request cycle.
REQ-029 Halt (macro on): word 32'hFC00_0000 fetched -> delivered valid, state=HALT next cycle, fe_gnt=0 thereafter; macro off -> remains RUN.
REQ-030 Reload/reset: reload asserted together with a halt return -> state=BOOT next cycle, instr_valid=0; rst=0 mid-fetch -> instr=0, instr_valid=0, state=BOOT.
